mul_seq_unit: RTL and testbench
===============================

# mul_seq_unit

Parametrised multi-cycle multiplier that succeeds the ALU's single-cycle MUL/SMULL/UMULL path. It uses the same operation codes and the same NZCV flag layout. The datapath is WIDTH bits wide and uses radix-2 shift-add iteration, one multiplier bit per cycle, behind a start/busy/done handshake. It sits beside the ALU in the execute stage, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand width in bits; legal for WIDTH ≥ 2. Product is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous and active-high.
- `start`  in  1  request. Sampled only in IDLE.
- `mul_op`  in  3  operation: 3'b100 MUL (signed, low word), 3'b110 SMULL, 3'b111 UMULL. All other codes are illegal.
- `a`  in  WIDTH  multiplicand. Sampled with `start`.
- `b`  in  WIDTH  multiplier. Sampled with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `err`  out  1  one-cycle pulse when `start` arrives with an illegal `mul_op`.
- `result`  out  WIDTH  low word of the product.
- `result_extra`  out  WIDTH  high word of the product.
- `flags`  out  4  {N,Z,C,V}.

## Operation
- States: IDLE → RUN → FIX → DONE → IDLE.
- IDLE with `start`=1 and a legal `mul_op`:
  - latch the op;
  - for MUL/SMULL, latch |a| and |b| and record sign = a[W-1]^b[W-1];
  - for UMULL, latch a and b raw with sign = 0;
  - clear the 2W accumulator, set counter = 0, go to RUN.
- |−2^(W-1)| = 2^(W-1) and fits in W unsigned bits. No special case is needed.
- IDLE with `start`=1 and an illegal `mul_op`: pulse `err` for one cycle, stay in IDLE, leave outputs unchanged.
- RUN, one step per cycle for WIDTH cycles:
  - if multiplier LSB = 1, add the multiplicand to the upper half of the accumulator (the carry is kept);
  - shift right by 1; shift the multiplier right by 1; counter++;
  - when counter = WIDTH−1 has been processed, go to FIX.
- FIX:
  - if sign = 1, P = −accumulator (2W two's complement), else P = accumulator;
  - write `result` = P[W-1:0] and `result_extra` = P[2W-1:W];
  - compute flags; go to DONE.
- Flags:
  - MUL: N = result[W-1]; Z = (result == 0); C = 0; V = 1 iff result_extra ≠ {W{result[W-1]}}, i.e. the signed product does not fit in WIDTH bits.
  - SMULL/UMULL: N = result_extra[W-1]; Z = (P == 0); C = 0; V = 0.
- DONE: `done` = 1 for this cycle only, then go to IDLE.
- `result`, `result_extra` and `flags` hold their values until the next FIX. They do not change on IDLE, on `err`, or on an ignored `start`.
- `start` in RUN, FIX or DONE is ignored and is not queued.
- `reset`=1 at any edge, including mid-RUN:
  - state → IDLE;
  - `busy`, `done`, `err` = 0;
  - `result`, `result_extra`, `flags`, accumulator and counter = 0;
  - the in-flight operation is discarded and no `done` follows.
- `reset` has priority over `start` in the same cycle.

## Timing
- Start is accepted at edge k.
- `busy` = 1 from after edge k until after edge k+WIDTH+2.
- RUN occupies edges k+1 … k+WIDTH.
- FIX writes outputs at edge k+WIDTH+1.
- `done` = 1 for the cycle between edges k+WIDTH+1 and k+WIDTH+2.
- Latency start-edge → done-high = WIDTH+1 cycles (33 for WIDTH=32).
- The earliest next accepted start is edge k+WIDTH+3, so throughput is one op per WIDTH+3 cycles.
- `err` is high for the cycle after the sampling edge. A legal start can be accepted at the next edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=32.
- MUL, a=−2 (fffffffe), b=3 → after 33 cycles `done` pulses once with result=fffffffa, result_extra=ffffffff, flags=1000; `busy` is low again 1 cycle later.
- SMULL, a=−5, b=10 → result=ffffffce, result_extra=ffffffff, flags=1000. UMULL, a=10, b=45 → result=000001c2, result_extra=00000000, flags=0000.
- MUL, a=b=00010000 → result=00000000, result_extra=00000001, flags=0101 (Z, V). SMULL, a=b=80000000 → result=00000000, result_extra=40000000, flags=0000. UMULL, a=b=ffffffff → result=00000001, result_extra=fffffffe, flags=1000.
- `mul_op`=3'b000 with `start` → `err`=1 for one cycle, `busy` stays 0, outputs unchanged. A UMULL start on the next edge is accepted normally.
- `start` with new operands held high during RUN → ignored; the first operation's result is reported exactly once, with no second `done`. Reset issued at RUN cycle 10 → next cycle state is IDLE with all outputs 0 and no `done`. A fresh op issued afterwards completes correctly in 33 cycles.
- Re-run the scenarios with WIDTH=8: a=−128, b=−128, SMULL → result=00, result_extra=40, done after 9 cycles. Check against a randomized reference product over 1000 operands per op.

Source files
------------

// File: rtl/mul_seq_unit.sv
// Multi-cycle radix-2 shift-add multiplier for MUL/SMULL/UMULL with NZCV flags.
// Magnitudes are multiplied unsigned; the sign is applied once in FIX.
module mul_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mul_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_extra,
  output logic [3:0]       flags
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_SMULL = 3'b110;
  localparam logic [2:0] OP_UMULL = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 sign_q, sign_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     extra_q, extra_d;
  logic [3:0]           flags_q, flags_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = $unsigned(v);
    return u[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                     input logic s);
    return s ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  function automatic logic [3:0] flags_of(input logic [2:0] op,
                                          input logic [2*WIDTH-1:0] p);
    logic [WIDTH-1:0] lo, hi;
    lo = p[WIDTH-1:0];
    hi = p[2*WIDTH-1:WIDTH];
    if (op == OP_MUL)
      return {lo[WIDTH-1], (lo == '0), 1'b0, (hi != {WIDTH{lo[WIDTH-1]}})};
    return {hi[WIDTH-1], (p == '0), 1'b0, 1'b0};
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    extra_d  = extra_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod     = apply_sign(acc_q, sign_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mul_op == OP_MUL || mul_op == OP_SMULL || mul_op == OP_UMULL) begin
            op_d  = mul_op;
            acc_d = '0;
            cnt_d = '0;
            state_d = RUN;
            if (mul_op == OP_UMULL) begin
              mcand_d  = a;
              mplier_d = b;
              sign_d   = 1'b0;
            end else begin
              mcand_d  = abs_w(a);
              mplier_d = abs_w(b);
              sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Carry out of the upper-half add becomes the new MSB after the shift.
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = prod[WIDTH-1:0];
        extra_d  = prod[2*WIDTH-1:WIDTH];
        flags_d  = flags_of(op_q, prod);
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      extra_q  <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      extra_q  <= extra_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    sign_q   <= sign_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign result       = result_q;
  assign result_extra = extra_q;
  assign flags        = flags_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit at WIDTH=32 and WIDTH=8, plus random products at WIDTH=8.
module tb_mul_seq_unit;

  logic        clk, reset;
  logic        start32, busy32, done32, err32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32, ext32;
  logic [3:0]  fl32;
  logic        start8, busy8, done8, err8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8, ext8;
  logic [3:0]  fl8;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] MUL = 3'b100, SMULL = 3'b110, UMULL = 3'b111;

  mul_seq_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .mul_op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .err(err32), .result(res32),
    .result_extra(ext32), .flags(fl32));

  mul_seq_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mul_op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .err(err8), .result(res8),
    .result_extra(ext8), .flags(fl8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] er,
                       input logic [31:0] ee, input logic [3:0] ef);
    int n;
    start32 = 1'b1; op32 = op; a32 = av; b32 = bv;
    tick();
    start32 = 1'b0;
    chk({tag, "_busy_start"}, busy32, 1);
    n = 0;
    while (!done32 && n < 100) begin tick(); n++; end
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_result"}, res32, er);
    chk({tag, "_extra"}, ext32, ee);
    chk({tag, "_flags"}, fl32, ef);
    chk({tag, "_busy_at_done"}, busy32, 1);
    tick();
    chk({tag, "_done_low"}, done32, 0);
    chk({tag, "_busy_low"}, busy32, 0);
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output logic [15:0] p, output logic [3:0] f);
    int n;
    start8 = 1'b1; op8 = op; a8 = av; b8 = bv;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 100) begin tick(); n++; end
    lat = n;
    p = {ext8, res8};
    f = fl8;
    tick();
  endtask

  initial begin
    int n, ndone, lat;
    logic [15:0] p, ep;
    logic [3:0]  f, ef;
    logic [7:0]  ra, rb;
    logic [2:0]  ops [3];
    logic signed [15:0] sa, sb;

    ops[0] = MUL; ops[1] = SMULL; ops[2] = UMULL;
    reset = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    tick(); tick();
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_err", err32, 0);
    chk("rst_result", {ext32, res32}, 64'h0);
    chk("rst_flags", fl32, 4'h0);
    reset = 1'b0;
    tick();

    run32("mul_m2x3", MUL, 32'hfffffffe, 32'd3, 32'hfffffffa, 32'hffffffff, 4'b1000);
    run32("smull_m5x10", SMULL, 32'hfffffffb, 32'd10, 32'hffffffce, 32'hffffffff, 4'b1000);
    run32("umull_10x45", UMULL, 32'd10, 32'd45, 32'h000001c2, 32'h0, 4'b0000);
    run32("mul_ovf", MUL, 32'h00010000, 32'h00010000, 32'h0, 32'h1, 4'b0101);
    run32("smull_min", SMULL, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 4'b0000);
    run32("umull_max", UMULL, 32'hffffffff, 32'hffffffff, 32'h1, 32'hfffffffe, 4'b1000);

    // Illegal op, then a legal start on the very next edge
    start32 = 1'b1; op32 = 3'b000; a32 = 32'd9; b32 = 32'd9;
    tick();
    chk("err_pulse", err32, 1);
    chk("err_busy", busy32, 0);
    chk("err_outputs_held", {ext32, res32}, {32'hfffffffe, 32'h1});
    chk("err_flags_held", fl32, 4'b1000);
    op32 = UMULL; a32 = 32'd7; b32 = 32'd6;
    tick();
    start32 = 1'b0;
    chk("err_one_cycle", err32, 0);
    chk("after_err_accept", busy32, 1);
    n = 0;
    while (!done32 && n < 100) begin tick(); n++; end
    chk("after_err_latency", n, 33);
    chk("after_err_result", {ext32, res32}, 64'd42);
    tick();

    // Start held high through the operation with different operands
    start32 = 1'b1; op32 = SMULL; a32 = 32'd3; b32 = 32'hfffffffc;
    tick();
    op32 = UMULL; a32 = 32'd100; b32 = 32'd100;
    n = 0;
    while (!done32 && n < 100) begin tick(); n++; end
    start32 = 1'b0;
    chk("held_latency", n, 33);
    chk("held_result", {ext32, res32}, 64'hfffffffffffffff4);
    chk("held_flags", fl32, 4'b1000);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done32) ndone++; end
    chk("held_no_second_done", ndone, 0);
    chk("held_idle", busy32, 0);

    // Reset during RUN
    start32 = 1'b1; op32 = MUL; a32 = 32'd5; b32 = 32'd7;
    tick();
    start32 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy32, 0);
    chk("midrst_done", done32, 0);
    chk("midrst_result", {ext32, res32}, 64'h0);
    chk("midrst_flags", fl32, 4'h0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done32) ndone++; end
    chk("midrst_no_done", ndone, 0);
    run32("post_rst_umull", UMULL, 32'd123456, 32'd1000, 32'h075bca00, 32'h0, 4'b0000);

    // WIDTH=8 directed
    run8(SMULL, 8'h80, 8'h80, lat, p, f);
    chk("w8_smull_lat", lat, 9);
    chk("w8_smull_prod", p, 16'h4000);
    chk("w8_smull_flags", f, 4'b0000);
    run8(MUL, 8'h80, 8'h80, lat, p, f);
    chk("w8_mul_prod", p, 16'h4000);
    chk("w8_mul_flags", f, 4'b0101);
    run8(UMULL, 8'hff, 8'hff, lat, p, f);
    chk("w8_umull_prod", p, 16'hfe01);
    chk("w8_umull_flags", f, 4'b1000);

    // WIDTH=8 random operands against an arithmetic reference
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if (ops[k] == UMULL) begin
          ep = {8'h0, ra} * {8'h0, rb};
        end else begin
          sa = {{8{ra[7]}}, ra};
          sb = {{8{rb[7]}}, rb};
          ep = 16'(sa * sb);
        end
        if (ops[k] == MUL)
          ef = {ep[7], (ep[7:0] == 8'h0), 1'b0, (ep[15:8] != {8{ep[7]}})};
        else
          ef = {ep[15], (ep == 16'h0), 1'b0, 1'b0};
        run8(ops[k], ra, rb, lat, p, f);
        chk($sformatf("w8_rand_op%0d_%h_%h_prod", ops[k], ra, rb), p, ep);
        chk($sformatf("w8_rand_op%0d_%h_%h_flags", ops[k], ra, rb), f, ef);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
